hbridge_drive_monitor: RTL



---
 rtl/hbridge_drive_monitor_pkg.sv | 32 +++
 rtl/hbridge_drive_monitor_deadtime_checker.sv | 46 ++++
 rtl/hbridge_drive_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hbridge_drive_monitor_pkg.sv
// Shared H-bridge drive definitions: bus patterns, default timing and sample decoding.
package hbridge_drive_monitor_pkg;

  // Drive bus patterns, shared with the PWM motor controller.
  localparam logic [3:0] DRIVE_IDLE = 4'b0000;
  localparam logic [3:0] DRIVE_FWD  = 4'b1001;
  localparam logic [3:0] DRIVE_REV  = 4'b0110;

  // Default timing: 1024-cycle PWM period, 500-cycle reversal dead time.
  localparam int PERIOD_BITS_DEFAULT = 10;
  localparam int DEAD_TIME_DEFAULT   = 500;

  typedef enum logic [1:0] {
    CLS_IDLE    = 2'd0,
    CLS_FWD     = 2'd1,
    CLS_REV     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } drive_class_e;

  // Anything other than the three legal patterns is an illegal drive.
  function automatic drive_class_e classify_drive(input logic [3:0] d);
    drive_class_e c;
    case (d)
      DRIVE_IDLE: c = CLS_IDLE;
      DRIVE_FWD:  c = CLS_FWD;
      DRIVE_REV:  c = CLS_REV;
      default:    c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hbridge_drive_monitor_deadtime_checker.sv
// Dead-time checker: counts idle cycles since the last non-idle sample and
// raises a one-cycle set pulse when the direction reverses too early.
module hbridge_drive_monitor_deadtime_checker
  import hbridge_drive_monitor_pkg::*;
#(
  parameter int DEAD_TIME = DEAD_TIME_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_active,   // current sample is FWD or REV
  input  logic sample_dir,      // 1 = FWD, 0 = REV (valid with sample_active)
  input  logic sample_illegal,  // current sample is not a legal pattern
  output logic deadtime_set
);

  localparam int GAP_W = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(DEAD_TIME);

  logic [GAP_W-1:0] gap_cnt_reg;
  logic             last_dir_reg;
  logic             last_dir_valid_reg;

  // Reversal check against the idle gap accumulated so far.
  always_comb begin
    deadtime_set = sample_active && last_dir_valid_reg &&
                   (sample_dir != last_dir_reg) && (gap_cnt_reg < GAP_MAX);
  end

  // Gap counter saturates at DEAD_TIME; illegal samples break the gap but keep the direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt_reg        <= GAP_MAX;
      last_dir_reg       <= 1'b0;
      last_dir_valid_reg <= 1'b0;
    end else if (sample_active) begin
      gap_cnt_reg        <= '0;
      last_dir_reg       <= sample_dir;
      last_dir_valid_reg <= 1'b1;
    end else if (sample_illegal) begin
      gap_cnt_reg <= '0;
    end else if (gap_cnt_reg < GAP_MAX) begin
      gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
    end
  end

endmodule

// File: rtl/hbridge_drive_monitor.sv
// Passive H-bridge drive monitor: measures duty/direction per 2^PERIOD_BITS
// window and keeps sticky illegal-pattern and dead-time fault flags.
module hbridge_drive_monitor
  import hbridge_drive_monitor_pkg::*;
#(
  parameter int PERIOD_BITS = PERIOD_BITS_DEFAULT,
  parameter int DEAD_TIME   = DEAD_TIME_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           drive,
  input  logic                 fault_clear,
  output logic                 meas_valid,
  output logic [PERIOD_BITS:0] meas_duty,
  output logic                 meas_on,
  output logic                 meas_dir,
  output logic                 meas_mixed,
  output logic                 illegal_fault,
  output logic                 deadtime_fault
);

  localparam logic [PERIOD_BITS-1:0] WIN_MAX = '1;

  logic [3:0]             drive_q_reg;
  logic                   run_reg;
  logic [PERIOD_BITS-1:0] win_cnt_reg;
  logic [PERIOD_BITS:0]   active_cnt_reg;
  logic                   seen_fwd_reg;
  logic                   seen_rev_reg;
  logic                   last_dir_win_reg;

  logic                   meas_valid_reg;
  logic [PERIOD_BITS:0]   meas_duty_reg;
  logic                   meas_on_reg;
  logic                   meas_dir_reg;
  logic                   meas_mixed_reg;
  logic                   illegal_fault_reg;
  logic                   deadtime_fault_reg;

  drive_class_e           cls;
  logic                   is_fwd;
  logic                   is_rev;
  logic                   is_active;
  logic                   is_illegal;
  logic                   win_end;
  logic [PERIOD_BITS:0]   duty_next;
  logic                   seen_fwd_next;
  logic                   seen_rev_next;
  logic                   dir_next;
  logic                   deadtime_set;

  // Single input register; every decision below works on drive_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      drive_q_reg <= DRIVE_IDLE;
    end else begin
      drive_q_reg <= drive;
    end
  end

  // Decode the registered sample and fold it into the running window totals.
  always_comb begin
    cls        = classify_drive(drive_q_reg);
    is_fwd     = (cls == CLS_FWD);
    is_rev     = (cls == CLS_REV);
    is_active  = is_fwd || is_rev;
    is_illegal = (cls == CLS_ILLEGAL);
    // run_reg holds the window off for the reset-value sample so the first
    // window covers the first 2^PERIOD_BITS real drive samples.
    win_end    = run_reg && (win_cnt_reg == WIN_MAX);
    duty_next     = active_cnt_reg + {{PERIOD_BITS{1'b0}}, is_active};
    seen_fwd_next = seen_fwd_reg || is_fwd;
    seen_rev_next = seen_rev_reg || is_rev;
    if (is_active) begin
      dir_next = is_fwd;
    end else if (seen_fwd_reg || seen_rev_reg) begin
      dir_next = last_dir_win_reg;
    end else begin
      dir_next = meas_dir_reg;  // no activity: keep the reported direction
    end
  end

  hbridge_drive_monitor_deadtime_checker #(
    .DEAD_TIME(DEAD_TIME)
  ) u_deadtime_checker (
    .clk            (clk),
    .reset          (reset),
    .sample_active  (is_active),
    .sample_dir     (is_fwd),
    .sample_illegal (is_illegal),
    .deadtime_set   (deadtime_set)
  );

  // Free-running window: accumulate each sample, publish and restart at window end.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_reg          <= 1'b0;
      win_cnt_reg      <= '0;
      active_cnt_reg   <= '0;
      seen_fwd_reg     <= 1'b0;
      seen_rev_reg     <= 1'b0;
      last_dir_win_reg <= 1'b0;
      meas_valid_reg   <= 1'b0;
      meas_duty_reg    <= '0;
      meas_on_reg      <= 1'b0;
      meas_dir_reg     <= 1'b0;
      meas_mixed_reg   <= 1'b0;
    end else begin
      run_reg        <= 1'b1;
      meas_valid_reg <= win_end;
      if (run_reg) begin
        win_cnt_reg <= win_cnt_reg + 1'b1;
      end
      if (win_end) begin
        meas_duty_reg    <= duty_next;
        meas_on_reg      <= (duty_next != '0);
        meas_dir_reg     <= dir_next;
        meas_mixed_reg   <= seen_fwd_next && seen_rev_next;
        active_cnt_reg   <= '0;
        seen_fwd_reg     <= 1'b0;
        seen_rev_reg     <= 1'b0;
        last_dir_win_reg <= 1'b0;
      end else if (run_reg) begin
        active_cnt_reg <= duty_next;
        seen_fwd_reg   <= seen_fwd_next;
        seen_rev_reg   <= seen_rev_next;
        if (is_active) begin
          last_dir_win_reg <= is_fwd;
        end
      end
    end
  end

  // Sticky fault flags; a new fault in the clearing cycle takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_fault_reg  <= 1'b0;
      deadtime_fault_reg <= 1'b0;
    end else begin
      if (is_illegal) begin
        illegal_fault_reg <= 1'b1;
      end else if (fault_clear) begin
        illegal_fault_reg <= 1'b0;
      end
      if (deadtime_set) begin
        deadtime_fault_reg <= 1'b1;
      end else if (fault_clear) begin
        deadtime_fault_reg <= 1'b0;
      end
    end
  end

  assign meas_valid     = meas_valid_reg;
  assign meas_duty      = meas_duty_reg;
  assign meas_on        = meas_on_reg;
  assign meas_dir       = meas_dir_reg;
  assign meas_mixed     = meas_mixed_reg;
  assign illegal_fault  = illegal_fault_reg;
  assign deadtime_fault = deadtime_fault_reg;

endmodule
